// File: rtl/fetch_unit.sv
// PC and instruction-fetch stage: holds the PC, addresses instruction memory,
// computes the next PC and sequences boot/run/halt with a retired counter.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   BOOT  | first cycle after reset, NOP presented, PC held
//   RUN   | fetching; PC advances unless stalled or halt word seen
//   HALT  | halt word fetched; NOP presented, everything frozen
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          IMEM_AW   = 10,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               is_jump,
    input  logic               is_branch,
    input  logic               branch_taken,
    input  logic               jump_reg,
    input  logic [31:0]        reg_target,
    input  logic [15:0]        imm16,
    input  logic [25:0]        addr26,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_data,
    output logic [31:0]        instruction,
    output logic [31:0]        pc,
    output logic [31:0]        pc_plus4,
    output logic               halted,
    output logic [31:0]        retired_count
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        advance;
    logic [31:0] branch_off;
    logic [31:0] next_pc;
    logic        unused_target_lsbs;

    // Word-aligned register targets drop their low bits without complaint.
    assign unused_target_lsbs = ^reg_target[1:0];

    assign pc_plus4   = pc + 32'd4;
    assign imem_addr  = pc[IMEM_AW+1:2];
    assign branch_off = {{14{imm16[15]}}, imm16, 2'b00};

    always_comb begin
        next_pc = pc_plus4;
        if (jump_reg) begin
            next_pc = {reg_target[31:2], 2'b00};
        end else if (is_jump) begin
            next_pc = {pc_plus4[31:28], addr26, 2'b00};
        end else if (is_branch && branch_taken) begin
            next_pc = pc_plus4 + branch_off;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            BOOT:    state_next = RUN;
            RUN:     if (imem_data == HALT_WORD) state_next = HALT;
            HALT:    state_next = HALT;
            default: state_next = BOOT;
        endcase
    end

    always_comb begin
        instruction = 32'h0000_0000;
        advance     = 1'b0;
        if (state == RUN) begin
            instruction = imem_data;
            advance     = (imem_data != HALT_WORD) && !stall;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc            <= RESET_PC;
            retired_count <= 32'd0;
            halted        <= 1'b0;
        end else begin
            halted <= (state_next == HALT);
            if (advance) begin
                pc            <= next_pc;
                retired_count <= retired_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed boot/branch/jump/stall/wrap/halt steps
// followed by randomized control, all checked against a behavioural model.
module tb_fetch_unit;

    localparam logic [31:0] HALT_W = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset, stall, is_jump, is_branch, branch_taken, jump_reg;
    logic [31:0] reg_target;
    logic [15:0] imm16;
    logic [25:0] addr26;
    logic [9:0]  imem_addr;
    logic [31:0] imem_data, instruction, pc, pc_plus4, retired_count;
    logic        halted;

    logic [31:0] mem [1024];
    assign imem_data = mem[imem_addr];

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .IMEM_AW  (10),
        .HALT_WORD(HALT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .is_jump      (is_jump),
        .is_branch    (is_branch),
        .branch_taken (branch_taken),
        .jump_reg     (jump_reg),
        .reg_target   (reg_target),
        .imm16        (imm16),
        .addr26       (addr26),
        .imem_addr    (imem_addr),
        .imem_data    (imem_data),
        .instruction  (instruction),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .halted       (halted),
        .retired_count(retired_count)
    );

    int total = 0;
    int bad   = 0;

    typedef enum {M_BOOT, M_RUN, M_HALT} mode_t;
    mode_t       mode;
    logic [31:0] m_pc;
    logic [31:0] m_cnt;
    logic [31:0] saved_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic set_ctl(input logic r, input logic st, input logic jr, input logic j,
                           input logic b, input logic bt, input logic [31:0] rt,
                           input logic [15:0] im, input logic [25:0] a);
        reset = r; stall = st; jump_reg = jr; is_jump = j;
        is_branch = b; branch_taken = bt; reg_target = rt; imm16 = im; addr26 = a;
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] p);
        return mem[(p / 4) % 1024];
    endfunction

    function automatic logic [31:0] target();
        logic [31:0] p4;
        p4 = m_pc + 32'd4;
        if (jump_reg) return reg_target & 32'hFFFF_FFFC;
        if (is_jump) return (p4 & 32'hF000_0000) | (32'(addr26) * 32'd4);
        if (is_branch && branch_taken) return p4 + 32'(int'($signed(imm16)) * 4);
        return p4;
    endfunction

    task automatic check_all();
        chk("pc", pc, m_pc);
        chk("pc_plus4", pc_plus4, m_pc + 32'd4);
        chk("imem_addr", {22'b0, imem_addr}, (m_pc / 4) % 1024);
        chk("instruction", instruction, (mode == M_RUN) ? word_at(m_pc) : 32'h0);
        chk("halted", {31'b0, halted}, {31'b0, mode == M_HALT});
        chk("retired", retired_count, m_cnt);
    endtask

    // Check at the falling edge, advance the model, then clock the DUT.
    task automatic tick();
        @(negedge clk);
        check_all();
        if (reset) begin
            m_pc = 32'h0; m_cnt = 32'h0; mode = M_BOOT;
        end else if (mode == M_BOOT) begin
            mode = M_RUN;
        end else if (mode == M_RUN) begin
            if (word_at(m_pc) == HALT_W) mode = M_HALT;
            else if (!stall) begin
                m_pc  = target();
                m_cnt = m_cnt + 32'd1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom;
        if (w == HALT_W) w = 32'h2000_0001;
        return w;
    endfunction

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = rand_instr();
        set_ctl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 26'h0);
        @(posedge clk);
        #1;
        m_pc = 32'h0; m_cnt = 32'h0; mode = M_BOOT;

        // Reset/boot
        tick();
        chk("boot_pc", pc, 32'h0);
        chk("boot_instr", instruction, 32'h0);
        reset = 1'b0;
        tick();
        chk("run0_instr", instruction, mem[0]);
        chk("run0_retired", retired_count, 32'h0);

        // Sequential run then taken branch at 0x0C
        tick(); tick(); tick();
        chk("seq_pc", pc, 32'h0C);
        set_ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 16'hFFFD, 26'h0);
        tick();
        chk("br_taken_pc", pc, 32'h04);
        chk("seq_retired", retired_count, 32'd4);

        // Misaligned register jump back to 0x0C, then untaken branch
        set_ctl(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_000E, 16'h0, 26'h0);
        tick();
        chk("jr_align_pc", pc, 32'h0C);
        set_ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 16'hFFFD, 26'h0);
        tick();
        chk("br_not_taken_pc", pc, 32'h10);

        // Jump priority
        set_ctl(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0103, 16'h0007, 26'h0000040);
        tick();
        chk("jr_priority_pc", pc, 32'h0000_0100);
        set_ctl(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h1000_0000, 16'h0, 26'h0);
        tick();
        set_ctl(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0, 16'h0005, 26'h0000040);
        tick();
        chk("jump_pc", pc, 32'h1000_0100);

        // Stall at 0x20
        set_ctl(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0020, 16'h0, 26'h0);
        tick();
        saved_cnt = m_cnt;
        for (int i = 0; i < 3; i++) begin
            set_ctl(1'b0, 1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                    $urandom, 16'($urandom), 26'($urandom));
            tick();
        end
        chk("stall_pc", pc, 32'h20);
        chk("stall_retired", retired_count, saved_cnt);

        // PC wrap
        set_ctl(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC, 16'h0, 26'h0);
        tick();
        set_ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 26'h0);
        tick();
        chk("wrap_pc", pc, 32'h0);

        // Halt at 0x18
        mem[6] = HALT_W;
        set_ctl(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0018, 16'h0, 26'h0);
        tick();
        saved_cnt = m_cnt;
        set_ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 26'h0);
        tick();
        chk("halt_flag", {31'b0, halted}, 32'h1);
        chk("halt_pc", pc, 32'h18);
        chk("halt_instr", instruction, 32'h0);
        chk("halt_retired", retired_count, saved_cnt);
        for (int i = 0; i < 2; i++) begin
            set_ctl(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                    1'($urandom), $urandom, 16'($urandom), 26'($urandom));
            tick();
        end
        chk("halt_hold_pc", pc, 32'h18);
        set_ctl(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0040, 16'h0, 26'h0);
        tick();
        chk("halt_reset_pc", pc, 32'h0);
        chk("halt_reset_flag", {31'b0, halted}, 32'h0);
        mem[6] = rand_instr();

        // Randomized phase
        for (int i = 0; i < 1024; i++)
            if ($urandom_range(0, 29) == 0) mem[i] = HALT_W;
        for (int n = 0; n < 600; n++) begin
            set_ctl(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0),
                    ($urandom_range(0, 2) == 0), 1'($urandom),
                    ($urandom_range(0, 1) == 0) ? $urandom : {20'h0, 12'($urandom)},
                    16'($urandom), 26'($urandom));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
